mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Memory-access stage plus MEM/WB pipeline register; producer of MEM_WB_RegisterRd/RegWrite/WriteData
//  consumed by forwarding and register-file write-back. Runs load/store via req/ack data-memory handshake,
//  aligns/extends load data, stalls upstream until memory responds. Sits between EX/MEM register and WB.
// PARAMETERS
//  XLEN        32  datapath width
//  REG_ADDR_W  5   register index width
// PORTS
//  clk                in   1      rising-edge clock
//  rst_n              in   1      asynchronous, active-low reset
//  ex_mem_valid       in   1      EX/MEM holds a real instruction
//  ex_mem_rd          in   5      destination register
//  ex_mem_reg_write   in   1      instruction writes rd
//  ex_mem_mem_read    in   1      load
//  ex_mem_mem_write   in   1      store
//  ex_mem_funct3      in   3      LB/LH/LW/LBU/LHU, SB/SH/SW encoding
//  ex_mem_alu_result  in   XLEN   address (mem op) or result (ALU op)
//  ex_mem_store_data  in   XLEN   rs2 value for stores
//  dmem_req           out  1      request valid, held until ack
//  dmem_we            out  1      1=store
//  dmem_addr          out  XLEN   word-aligned address (addr[1:0]=0)
//  dmem_wdata         out  XLEN   lane-replicated store data
//  dmem_be            out  4      byte enables
//  dmem_ack           in   1      one-cycle completion pulse
//  dmem_rdata         in   XLEN   read word, valid with ack
//  mem_stall          out  1      upstream must hold EX/MEM and earlier stages
//  misalign_fault     out  1      one-cycle pulse, misaligned access dropped
//  MEM_WB_RegisterRd  out  5      registered rd
//  MEM_WB_RegWrite    out  1      registered write enable
//  MEM_WB_WriteData   out  XLEN   registered write-back value
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; all outputs 0; dmem_req drops same instant.
//  FSM states IDLE, WAIT_ACK.
//  IDLE, valid non-mem instr: next edge MEM/WB <= {rd, reg_write, alu_result}; latency 1; no stall.
//  IDLE, !valid: MEM/WB <= bubble (RegWrite=0, Rd=0, Data=0).
//  IDLE, valid aligned mem op: mem_stall=1 combinationally; edge latches addr/be/wdata/rd/funct3/reg_write,
//   goes WAIT_ACK, dmem_req=1 from latched regs; MEM/WB <= bubble.
//  WAIT_ACK, !ack: mem_stall=1, dmem_req/addr/we/be/wdata held stable, MEM/WB <= bubble.
//  WAIT_ACK, ack: mem_stall=0 same cycle (upstream advances at this edge); edge: dmem_req=0, ->IDLE;
//   load: MEM/WB <= {rd, reg_write, extended}; store: MEM/WB <= bubble. Minimum mem-op latency 2 cycles.
//  Ack in IDLE ignored (covers stale ack after mid-transaction reset).
//  Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; byte always aligned.
//   Misaligned: no request, no stall, misalign_fault=1 for the cycle after, MEM/WB <= bubble.
//  Store lanes: SB be=4'b0001<<a[1:0], wdata={4{d[7:0]}}; SH be=a[1]?1100:0011, wdata={2{d[15:0]}};
//   SW be=1111, wdata=d.
//  Load extract: byte lane a[1:0], half lane a[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass.
//  rd==0: RegWrite forced 0 in MEM/WB (forwarding never sees x0 writes).
//  Undefined funct3 with mem op: treated as word access.
// STRUCTURE
//  Shared pkg rv_mem_pkg: FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW localparams, state encoding
//   (IDLE=1'b0, WAIT_ACK=1'b1).
//  Sub-module load_extend: comb (rdata, addr[1:0], funct3) -> XLEN result.
//  Top: FSM, request latch, alignment check, store lane logic, MEM/WB register.
// TESTING
//  ALU op rd=5 result 0x1234 -> next cycle Rd=5, RegWrite=1, Data=0x1234; mem_stall never high.
//  LB addr 0x103, ack after 3 cycles, rdata=0x80_00_00_00 -> dmem_addr=0x100; stall 4 cycles;
//   Data=0xFFFFFF80.
//  SH addr 0x202 data 0xABCD -> be=1100, wdata=0xABCDABCD, we=1; after ack RegWrite=0.
//  LW addr 0x101 -> no dmem_req, misalign_fault pulse 1 cycle, bubble, no stall.
//  Load in WAIT_ACK, rst_n low -> dmem_req 0 immediately; ack after release ignored, outputs stay 0.
//  LBU rd=0 addr 0x3 rdata=0xF0000000 -> Data=0x000000F0, RegWrite=0.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared encodings for the memory stage: funct3 load/store codes, FSM states,
// access-size classification and the alignment rule.
package rv_mem_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Any funct3 that is not a defined byte/half code falls back to a word access.
  function automatic acc_size_e access_size(input logic is_store, input logic [2:0] f3);
    acc_size_e sz;
    sz = SZ_WORD;
    if (f3 == FUNCT3_SB || (!is_store && f3 == FUNCT3_LBU)) begin
      sz = SZ_BYTE;
    end else if (f3 == FUNCT3_SH || (!is_store && f3 == FUNCT3_LHU)) begin
      sz = SZ_HALF;
    end
    return sz;
  endfunction

  function automatic logic misaligned(input acc_size_e sz, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (sz)
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Load data alignment: picks the addressed byte/half lane and sign/zero extends.
module load_extend
  import rv_mem_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select, then extension chosen by funct3 (unknown codes pass the word).
  always_comb begin
    byte_v   = rdata_i[{addr_i, 3'b000} +: 8];
    half_v   = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    result_o = rdata_i;
    case (funct3_i)
      FUNCT3_LB:  result_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      FUNCT3_LBU: result_o = {{(XLEN-8){1'b0}}, byte_v};
      FUNCT3_LH:  result_o = {{(XLEN-16){half_v[15]}}, half_v};
      FUNCT3_LHU: result_o = {{(XLEN-16){1'b0}}, half_v};
      default:    result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register. Issues one load/store at a
// time over a req/ack data-memory handshake and stalls upstream until ack.
module mem_wb_stage
  import rv_mem_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_mem_valid,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic                  ex_mem_reg_write,
  input  logic                  ex_mem_mem_read,
  input  logic                  ex_mem_mem_write,
  input  logic [2:0]            ex_mem_funct3,
  input  logic [XLEN-1:0]       ex_mem_alu_result,
  input  logic [XLEN-1:0]       ex_mem_store_data,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ack,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  mem_stall,
  output logic                  misalign_fault,
  output logic [REG_ADDR_W-1:0] MEM_WB_RegisterRd,
  output logic                  MEM_WB_RegWrite,
  output logic [XLEN-1:0]       MEM_WB_WriteData
);

  mem_state_e state_q, state_d;

  logic                  is_mem, mis, start_req, fault_d, fault_q;
  acc_size_e             sz;
  logic [1:0]            off;
  logic [3:0]            be_d;
  logic [XLEN-1:0]       wdata_d;
  logic [XLEN-1:0]       load_data;

  logic [XLEN-1:0]       req_addr_q, req_wdata_q;
  logic [3:0]            req_be_q;
  logic                  req_we_q, req_rw_q;
  logic [REG_ADDR_W-1:0] req_rd_q;
  logic [2:0]            req_f3_q;

  logic [REG_ADDR_W-1:0] wb_rd_d, wb_rd_q;
  logic                  wb_we_d, wb_we_q;
  logic [XLEN-1:0]       wb_data_d, wb_data_q;

  // Decode the incoming instruction: size, alignment, store lane placement.
  always_comb begin
    is_mem    = ex_mem_mem_read | ex_mem_mem_write;
    off       = ex_mem_alu_result[1:0];
    sz        = access_size(ex_mem_mem_write, ex_mem_funct3);
    mis       = misaligned(sz, off);
    start_req = (state_q == IDLE) && ex_mem_valid && is_mem && !mis;
    fault_d   = (state_q == IDLE) && ex_mem_valid && is_mem && mis;
    be_d      = 4'b1111;
    wdata_d   = ex_mem_store_data;
    case (sz)
      SZ_BYTE: begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{ex_mem_store_data[7:0]}};
      end
      SZ_HALF: begin
        be_d    = off[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{ex_mem_store_data[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = ex_mem_store_data;
      end
    endcase
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata_i  (dmem_rdata),
    .addr_i   (req_addr_q[1:0]),
    .funct3_i (req_f3_q),
    .result_o (load_data)
  );

  // Next state, upstream stall and MEM/WB next value (bubble by default).
  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    wb_rd_d   = '0;
    wb_we_d   = 1'b0;
    wb_data_d = '0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d   = WAIT_ACK;
          mem_stall = 1'b1;
        end else if (ex_mem_valid && !is_mem) begin
          wb_rd_d   = ex_mem_rd;
          wb_we_d   = ex_mem_reg_write && (ex_mem_rd != '0);
          wb_data_d = ex_mem_alu_result;
        end
      end
      WAIT_ACK: begin
        if (dmem_ack) begin
          state_d = IDLE;
          if (!req_we_q) begin
            wb_rd_d   = req_rd_q;
            wb_we_d   = req_rw_q && (req_rd_q != '0);
            wb_data_d = load_data;
          end
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and one-cycle misalignment pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Request latch: captured when a transaction starts, held until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      req_we_q    <= 1'b0;
      req_rw_q    <= 1'b0;
      req_rd_q    <= '0;
      req_f3_q    <= '0;
    end else if (start_req) begin
      req_addr_q  <= ex_mem_alu_result;
      req_wdata_q <= wdata_d;
      req_be_q    <= be_d;
      req_we_q    <= ex_mem_mem_write;
      req_rw_q    <= ex_mem_reg_write;
      req_rd_q    <= ex_mem_rd;
      req_f3_q    <= ex_mem_funct3;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rd_q   <= '0;
      wb_we_q   <= 1'b0;
      wb_data_q <= '0;
    end else begin
      wb_rd_q   <= wb_rd_d;
      wb_we_q   <= wb_we_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign dmem_req          = (state_q == WAIT_ACK);
  assign dmem_we           = req_we_q;
  assign dmem_addr         = {req_addr_q[XLEN-1:2], 2'b00};
  assign dmem_wdata        = req_wdata_q;
  assign dmem_be           = req_be_q;
  assign misalign_fault    = fault_q;
  assign MEM_WB_RegisterRd = wb_rd_q;
  assign MEM_WB_RegWrite   = wb_we_q;
  assign MEM_WB_WriteData  = wb_data_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: single-cycle vector table, memory
// transaction table, and a hand-written mid-transaction reset sequence.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_mem_valid;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_reg_write;
  logic        ex_mem_mem_read;
  logic        ex_mem_mem_write;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_store_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        misalign_fault;
  logic [4:0]  MEM_WB_RegisterRd;
  logic        MEM_WB_RegWrite;
  logic [31:0] MEM_WB_WriteData;

  int unsigned n_app;
  int unsigned n_bad;

  mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_reg_write  (ex_mem_reg_write),
    .ex_mem_mem_read   (ex_mem_mem_read),
    .ex_mem_mem_write  (ex_mem_mem_write),
    .ex_mem_funct3     (ex_mem_funct3),
    .ex_mem_alu_result (ex_mem_alu_result),
    .ex_mem_store_data (ex_mem_store_data),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_be           (dmem_be),
    .dmem_ack          (dmem_ack),
    .dmem_rdata        (dmem_rdata),
    .mem_stall         (mem_stall),
    .misalign_fault    (misalign_fault),
    .MEM_WB_RegisterRd (MEM_WB_RegisterRd),
    .MEM_WB_RegWrite   (MEM_WB_RegWrite),
    .MEM_WB_WriteData  (MEM_WB_WriteData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic [31:0] e_data;
    logic        e_fault;
  } vec_t;

  typedef struct {
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        rw;
    int unsigned waits;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic [31:0] e_data;
    int unsigned e_stalls;
  } mem_t;

  vec_t vt[11];
  mem_t mt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_app++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ex_mem_valid      = 1'b0;
    ex_mem_rd         = '0;
    ex_mem_reg_write  = 1'b0;
    ex_mem_mem_read   = 1'b0;
    ex_mem_mem_write  = 1'b0;
    ex_mem_funct3     = '0;
    ex_mem_alu_result = '0;
    ex_mem_store_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned stalls;
    n_app = 0;
    n_bad = 0;

    //            valid rd   rw mr mw f3    alu           e_rd e_rw e_data        e_fault
    vt[0]  = '{1'b1, 5'd5,  1, 0, 0, 3'd0, 32'h0000_1234, 5'd5,  1, 32'h0000_1234, 0};
    vt[1]  = '{1'b1, 5'd0,  1, 0, 0, 3'd0, 32'h0000_DEAD, 5'd0,  0, 32'h0000_DEAD, 0};
    vt[2]  = '{1'b0, 5'd7,  1, 0, 0, 3'd0, 32'h0000_0055, 5'd0,  0, 32'h0,         0};
    vt[3]  = '{1'b1, 5'd31, 0, 0, 0, 3'd0, 32'hFFFF_FFFF, 5'd31, 0, 32'hFFFF_FFFF, 0};
    vt[4]  = '{1'b1, 5'd3,  1, 1, 0, 3'd2, 32'h0000_0101, 5'd0,  0, 32'h0,         1};
    vt[5]  = '{1'b1, 5'd1,  1, 0, 0, 3'd0, 32'h0000_0007, 5'd1,  1, 32'h0000_0007, 0};
    vt[6]  = '{1'b1, 5'd2,  1, 1, 0, 3'd1, 32'h0000_0103, 5'd0,  0, 32'h0,         1};
    vt[7]  = '{1'b1, 5'd0,  0, 0, 1, 3'd2, 32'h0000_0202, 5'd0,  0, 32'h0,         1};
    vt[8]  = '{1'b1, 5'd0,  0, 0, 1, 3'd1, 32'h0000_0003, 5'd0,  0, 32'h0,         1};
    vt[9]  = '{1'b1, 5'd4,  1, 1, 0, 3'd6, 32'h0000_000A, 5'd0,  0, 32'h0,         1};
    vt[10] = '{1'b0, 5'd3,  1, 1, 0, 3'd2, 32'h0000_0101, 5'd0,  0, 32'h0,         0};

    //           mr mw f3    addr          sdata          rd     rw waits rdata          e_addr         e_be     e_wdata        e_rd   e_rw e_data         e_stalls
    mt[0] = '{1, 0, 3'd0, 32'h0000_0103, 32'h0,         5'd6,  1, 3, 32'h8000_0000, 32'h0000_0100, 4'b0000, 32'h0,         5'd6,  1, 32'hFFFF_FF80, 4};
    mt[1] = '{0, 1, 3'd1, 32'h0000_0202, 32'h0000_ABCD, 5'd0,  0, 1, 32'h0,         32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 5'd0,  0, 32'h0,         2};
    mt[2] = '{0, 1, 3'd0, 32'h0000_0001, 32'h1234_565A, 5'd0,  0, 0, 32'h0,         32'h0000_0000, 4'b0010, 32'h5A5A_5A5A, 5'd0,  0, 32'h0,         1};
    mt[3] = '{0, 1, 3'd2, 32'h0000_0300, 32'h1234_5678, 5'd0,  0, 2, 32'h0,         32'h0000_0300, 4'b1111, 32'h1234_5678, 5'd0,  0, 32'h0,         3};
    mt[4] = '{1, 0, 3'd4, 32'h0000_0003, 32'h0,         5'd0,  1, 0, 32'hF000_0000, 32'h0000_0000, 4'b0000, 32'h0,         5'd0,  0, 32'h0000_00F0, 1};
    mt[5] = '{1, 0, 3'd1, 32'h0000_0002, 32'h0,         5'd9,  1, 1, 32'h8001_0000, 32'h0000_0000, 4'b0000, 32'h0,         5'd9,  1, 32'hFFFF_8001, 2};
    mt[6] = '{1, 0, 3'd5, 32'h0000_0010, 32'h0,         5'd10, 1, 0, 32'h0000_8001, 32'h0000_0010, 4'b0000, 32'h0,         5'd10, 1, 32'h0000_8001, 1};
    mt[7] = '{1, 0, 3'd2, 32'h0000_0400, 32'h0,         5'd11, 1, 1, 32'hDEAD_BEEF, 32'h0000_0400, 4'b0000, 32'h0,         5'd11, 1, 32'hDEAD_BEEF, 2};
    mt[8] = '{1, 0, 3'd3, 32'h0000_0008, 32'h0,         5'd12, 1, 0, 32'h1122_3344, 32'h0000_0008, 4'b0000, 32'h0,         5'd12, 1, 32'h1122_3344, 1};
    mt[9] = '{1, 0, 3'd0, 32'h0000_0105, 32'h0,         5'd13, 1, 2, 32'h0000_7F00, 32'h0000_0104, 4'b0000, 32'h0,         5'd13, 1, 32'h0000_007F, 3};

    // Reset state.
    rst_n      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    clear_inputs();
    #12;
    chk("rst_req",   {31'b0, dmem_req}, 32'h0);
    chk("rst_stall", {31'b0, mem_stall}, 32'h0);
    chk("rst_fault", {31'b0, misalign_fault}, 32'h0);
    chk("rst_rd",    {27'b0, MEM_WB_RegisterRd}, 32'h0);
    chk("rst_rw",    {31'b0, MEM_WB_RegWrite}, 32'h0);
    chk("rst_data",  MEM_WB_WriteData, 32'h0);
    chk("rst_addr",  dmem_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single-cycle vectors: ALU ops, bubbles, misaligned drops.
    for (int i = 0; i < 11; i++) begin
      ex_mem_valid      = vt[i].valid;
      ex_mem_rd         = vt[i].rd;
      ex_mem_reg_write  = vt[i].rw;
      ex_mem_mem_read   = vt[i].mr;
      ex_mem_mem_write  = vt[i].mw;
      ex_mem_funct3     = vt[i].f3;
      ex_mem_alu_result = vt[i].alu;
      ex_mem_store_data = 32'hCAFE_F00D;
      #1;
      chk($sformatf("v%0d_stall", i), {31'b0, mem_stall}, 32'h0);
      tick();
      chk($sformatf("v%0d_rd", i),    {27'b0, MEM_WB_RegisterRd}, {27'b0, vt[i].e_rd});
      chk($sformatf("v%0d_rw", i),    {31'b0, MEM_WB_RegWrite}, {31'b0, vt[i].e_rw});
      chk($sformatf("v%0d_data", i),  MEM_WB_WriteData, vt[i].e_data);
      chk($sformatf("v%0d_fault", i), {31'b0, misalign_fault}, {31'b0, vt[i].e_fault});
      chk($sformatf("v%0d_req", i),   {31'b0, dmem_req}, 32'h0);
    end
    clear_inputs();
    tick();
    chk("fault_pulse_end", {31'b0, misalign_fault}, 32'h0);

    // Memory transactions with a bounded, table-given ack delay.
    for (int i = 0; i < 10; i++) begin
      ex_mem_valid      = 1'b1;
      ex_mem_rd         = mt[i].rd;
      ex_mem_reg_write  = mt[i].rw;
      ex_mem_mem_read   = mt[i].mr;
      ex_mem_mem_write  = mt[i].mw;
      ex_mem_funct3     = mt[i].f3;
      ex_mem_alu_result = mt[i].addr;
      ex_mem_store_data = mt[i].sdata;
      #1;
      stalls = 0;
      if (mem_stall) stalls++;
      chk($sformatf("m%0d_req_pre", i), {31'b0, dmem_req}, 32'h0);
      tick();
      chk($sformatf("m%0d_bubble_rw", i), {31'b0, MEM_WB_RegWrite}, 32'h0);
      for (int unsigned w = 0; w < mt[i].waits; w++) begin
        chk($sformatf("m%0d_w%0d_req", i, w), {31'b0, dmem_req}, 32'h1);
        chk($sformatf("m%0d_w%0d_addr", i, w), dmem_addr, mt[i].e_addr);
        if (mem_stall) stalls++;
        tick();
      end
      chk($sformatf("m%0d_req", i),  {31'b0, dmem_req}, 32'h1);
      chk($sformatf("m%0d_addr", i), dmem_addr, mt[i].e_addr);
      chk($sformatf("m%0d_we", i),   {31'b0, dmem_we}, {31'b0, mt[i].mw});
      if (mt[i].mw) begin
        chk($sformatf("m%0d_be", i),    {28'b0, dmem_be}, {28'b0, mt[i].e_be});
        chk($sformatf("m%0d_wdata", i), dmem_wdata, mt[i].e_wdata);
      end
      dmem_ack   = 1'b1;
      dmem_rdata = mt[i].rdata;
      #1;
      chk($sformatf("m%0d_ack_stall", i), {31'b0, mem_stall}, 32'h0);
      chk($sformatf("m%0d_stall_cycles", i), stalls, mt[i].e_stalls);
      tick();
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      clear_inputs();
      chk($sformatf("m%0d_req_post", i), {31'b0, dmem_req}, 32'h0);
      chk($sformatf("m%0d_rd", i),   {27'b0, MEM_WB_RegisterRd}, {27'b0, mt[i].e_rd});
      chk($sformatf("m%0d_rw", i),   {31'b0, MEM_WB_RegWrite}, {31'b0, mt[i].e_rw});
      chk($sformatf("m%0d_data", i), MEM_WB_WriteData, mt[i].e_data);
    end

    // Reset mid-transaction, then a stale ack in IDLE.
    ex_mem_valid      = 1'b1;
    ex_mem_rd         = 5'd4;
    ex_mem_reg_write  = 1'b1;
    ex_mem_mem_read   = 1'b1;
    ex_mem_funct3     = 3'd2;
    ex_mem_alu_result = 32'h0000_0500;
    tick();
    chk("rstmid_req_before", {31'b0, dmem_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("rstmid_req",   {31'b0, dmem_req}, 32'h0);
    chk("rstmid_stall", {31'b0, mem_stall}, 32'h0);
    chk("rstmid_addr",  dmem_addr, 32'h0);
    chk("rstmid_rw",    {31'b0, MEM_WB_RegWrite}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("stale_ack_stall", {31'b0, mem_stall}, 32'h0);
    tick();
    dmem_ack = 1'b0;
    chk("stale_ack_req",  {31'b0, dmem_req}, 32'h0);
    chk("stale_ack_rd",   {27'b0, MEM_WB_RegisterRd}, 32'h0);
    chk("stale_ack_rw",   {31'b0, MEM_WB_RegWrite}, 32'h0);
    chk("stale_ack_data", MEM_WB_WriteData, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_app, n_bad);
    $finish;
  end

endmodule
